// File: rtl/md_unit_ctrl.sv
// EX-stage multiply/divide sequencer: runs one MD operation for a fixed latency,
// commits to HI/LO on completion and services mthi/mtlo and the mfhi/mflo read path.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic        start,
   input  logic        d_md_use,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rd_sel,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;
   logic          pend_we_q, busy_q;

   logic          md_go;
   logic [31:0]   res_hi_d, res_lo_d;
   logic          res_we_d;
   logic [CW-1:0] cnt_d;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] sdiv_raw_q, sdiv_raw_r;
   logic [31:0]        sdiv_q, sdiv_r, udiv_q, udiv_r;
   logic               div_ovf;

   assign md_go = start && (md_op >= 3'd1) && (md_op <= 3'd4);

   assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // The most-negative / -1 quotient overflows 32 bits; MIPS wraps it back to itself.
   assign div_ovf    = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
   assign sdiv_raw_q = $signed(rs_data) / $signed(rt_data);
   assign sdiv_raw_r = $signed(rs_data) % $signed(rt_data);
   assign sdiv_q     = div_ovf ? 32'h8000_0000 : sdiv_raw_q;
   assign sdiv_r     = div_ovf ? 32'h0000_0000 : sdiv_raw_r;
   assign udiv_q     = rs_data / rt_data;
   assign udiv_r     = rs_data % rt_data;

   always_comb begin
      res_hi_d = 32'd0;
      res_lo_d = 32'd0;
      res_we_d = 1'b1;
      cnt_d    = CW'(DIV_CYCLES);
      case (md_op)
         3'd1: begin
            res_hi_d = prod_s[63:32];
            res_lo_d = prod_s[31:0];
            cnt_d    = CW'(MULT_CYCLES);
         end
         3'd2: begin
            res_hi_d = prod_u[63:32];
            res_lo_d = prod_u[31:0];
            cnt_d    = CW'(MULT_CYCLES);
         end
         3'd3: begin
            res_hi_d = sdiv_r;
            res_lo_d = sdiv_q;
            res_we_d = (rt_data != 32'd0);
         end
         3'd4: begin
            res_hi_d = udiv_r;
            res_lo_d = udiv_q;
            res_we_d = (rt_data != 32'd0);
         end
         default: res_we_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_we_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (md_go) begin
                  pend_hi_q <= res_hi_d;
                  pend_lo_q <= res_lo_d;
                  pend_we_q <= res_we_d;
                  cnt_q     <= cnt_d;
                  busy_q    <= 1'b1;
                  state_q   <= RUN;
               end else if (md_op == 3'd5) begin
                  hi_q <= rs_data;
               end else if (md_op == 3'd6) begin
                  lo_q <= rs_data;
               end
            end
            RUN: begin
               // Divide-by-zero still occupies the unit but never commits.
               if (cnt_q == CW'(1)) begin
                  if (pend_we_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign stall_req = d_md_use & (busy_q | start);
   assign md_rdata  = rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed test-plan scenarios followed by random traffic,
// all checked against a cycle-level arithmetic model of HI/LO and the remaining latency.
module tb_md_unit_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, start, d_md_use, rd_sel;
   logic [2:0]  md_op;
   logic [31:0] rs_data, rt_data;
   logic        busy, stall_req;
   logic [31:0] hi, lo, md_rdata;

   md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .md_op(md_op), .start(start), .d_md_use(d_md_use),
      .rs_data(rs_data), .rt_data(rt_data), .rd_sel(rd_sel),
      .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .md_rdata(md_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   bit          m_pok = 0;
   int          m_rem = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference: what the architecture says happens at one clock edge given current inputs.
   task automatic model_edge();
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     r, q;
      sa = $signed(rs_data);
      sb = $signed(rt_data);
      ua = rs_data;
      ub = rt_data;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_rem = 0; m_pok = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && m_pok) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (start && md_op >= 3'd1 && md_op <= 3'd4) begin
         $display("txn op=%0d rs=%08h rt=%08h", md_op, rs_data, rt_data);
         m_pok = 1;
         case (md_op)
            3'd1: begin r = sa * sb; m_phi = r[63:32]; m_plo = r[31:0]; m_rem = MC; end
            3'd2: begin r = ua * ub; m_phi = r[63:32]; m_plo = r[31:0]; m_rem = MC; end
            3'd3: begin
               m_rem = DC;
               if (sb == 0) m_pok = 0;
               else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
            end
            default: begin
               m_rem = DC;
               if (ub == 0) m_pok = 0;
               else begin q = ua / ub; r = ua % ub; m_plo = q[31:0]; m_phi = r[31:0]; end
            end
         endcase
      end else if (md_op == 3'd5) begin
         m_hi = rs_data;
      end else if (md_op == 3'd6) begin
         m_lo = rs_data;
      end
   endtask

   task automatic cycle(input logic rst, input logic [2:0] op, input logic st, input logic use_md,
                        input logic [31:0] a, input logic [31:0] b, input logic sel);
      logic exp_stall;
      reset = rst; md_op = op; start = st; d_md_use = use_md;
      rs_data = a; rt_data = b; rd_sel = sel;
      #1;
      exp_stall = use_md & ((m_rem > 0) | st);
      check("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
      check("md_rdata", md_rdata, sel ? m_hi : m_lo);
      @(posedge clk);
      model_edge();
      #1;
      check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
   endtask

   task automatic idle(input int n, input logic use_md);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, use_md, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      reset = 1'b1; md_op = 0; start = 0; d_md_use = 0; rs_data = 0; rt_data = 0; rd_sel = 0;
      cycle(1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check("rst_busy", {31'd0, busy}, 32'd0);

      // mult -2*3 with an MD instruction in D throughout; mtlo attempted while busy
      cycle(1'b0, 3'd1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      cycle(1'b0, 3'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 3'd6, 1'b0, 1'b1, 32'h0000_ABCD, 32'd0, 1'b0);
      idle(2, 1'b1);
      check("mult_hold_lo", lo, 32'd0);
      idle(1, 1'b1);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      idle(1, 1'b1);

      cycle(1'b0, 3'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(MC, 1'b0);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      cycle(1'b0, 3'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(DC, 1'b0);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_lo", lo, 32'hFFFF_FFFD);

      cycle(1'b0, 3'd5, 1'b0, 1'b0, 32'h11, 32'd0, 1'b0);
      cycle(1'b0, 3'd6, 1'b0, 1'b0, 32'h22, 32'd0, 1'b0);
      cycle(1'b0, 3'd4, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0);
      idle(DC - 1, 1'b0);
      check("divz_busy", {31'd0, busy}, 32'd1);
      idle(1, 1'b0);
      check("divz_hi", hi, 32'h11);
      check("divz_lo", lo, 32'h22);

      cycle(1'b0, 3'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(DC, 1'b0);
      check("ovf_hi", hi, 32'h0);
      check("ovf_lo", lo, 32'h8000_0000);

      cycle(1'b0, 3'd5, 1'b1, 1'b0, 32'h1234, 32'd0, 1'b0);
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check("mthi_rdata", md_rdata, 32'h1234);

      // reset lands in the third cycle of a divide
      cycle(1'b0, 3'd3, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      idle(2, 1'b0);
      cycle(1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      idle(DC + 2, 1'b0);
      check("rst_no_commit", hi, 32'd0);

      for (int i = 0; i < 1500; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) a = {{28{a[31]}}, a[3:0]};
         cycle(($urandom_range(0, 199) == 0), op, ($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multiply/divide sequencer for the pipelined MIPS core; sits in the EX stage beside the ALU.
- Accepts one mult/multu/div/divu per start pulse and holds it for a fixed multi-cycle latency, reporting busy.
- Commits results to HI/LO at completion, services mfhi/mflo/mthi/mtlo, and raises stall_req so hazard control freezes F/D while an MD-dependent instruction waits.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved (treated as none).
- start  input  1  EX-stage instruction is mult/multu/div/divu; qualifies md_op 1-4.
- d_md_use  input  1  D-stage instruction is any MD instruction (including mfhi/mflo).
- rs_data  input  32  operand A / mthi-mtlo source.
- rt_data  input  32  operand B.
- rd_sel  input  1  0 selects LO, 1 selects HI for md_rdata.
- busy  output  1  operation in flight.
- stall_req  output  1  equals d_md_use & (busy | start).
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_rdata  output  32  rd_sel ? hi : lo, combinational (mfhi/mflo path).

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending results=0, stall_req follows its equation.
- Reset mid-operation cancels the operation; HI/LO never receive the pending result.
- States: IDLE and RUN.
- IDLE to RUN: start=1 with md_op in 1..4 at edge k.
  - Operands are captured and the result is computed into pending_hi/pending_lo.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 for cycles k+1 .. k+N.
- RUN: the counter decrements each edge. At the edge where counter==1, hi/lo are loaded from the pending values, busy falls, and the state returns to IDLE.
- New HI/LO are visible exactly N cycles after the start edge. During busy, hi/lo and md_rdata show the old values.
- start asserted while busy is ignored; no restart and no queueing. Hazard control guarantees this does not occur.
- mthi/mtlo (md_op 5/6, start ignored):
  - In IDLE, write rs_data to hi/lo at the next edge.
  - In RUN, ignored.
  - Same-cycle start with md_op 5/6 is not an operation.
- Arithmetic:
  - mult: signed 32x32 to 64, hi=[63:32], lo=[31:0].
  - multu: unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (rt_data=0): the operation still runs DIV_CYCLES with busy=1; hi/lo are left unchanged at completion.
- stall_req is combinational. It is asserted in the start cycle itself, so an MD instruction directly behind a start stalls immediately.

Test Plan:
- mult: rs=0xFFFFFFFE (-2), rt=3, start at edge k.
  - Required: busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Required: hi/lo hold their old values through cycle k+4.
- multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF.
  - Required: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- div: rs=0xFFFFFFF9 (-7), rt=2.
  - Required: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu: rs=7, rt=0 with prior hi=0x11, lo=0x22.
  - Required: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- mtlo 0xABCD while busy from a mult.
  - Required: the write is ignored; lo equals the mult result at completion.
- mthi 0x1234 in IDLE, followed by rd_sel=1.
  - Required: md_rdata=0x1234 in the next cycle.
- d_md_use=1 together with start.
  - Required: stall_req=1 from the start cycle through the last busy cycle, and 0 after.
- reset asserted at cycle 3 of a div.
  - Required: next cycle busy=0, hi=lo=0, and no late commit.
